fpusqr_sched: RTL and testbench

- Issue/retire scheduler for the four iterative rt2_fp sqrt/divide engines inside the FP sqrt/div functional unit.
- Takes one new sqrt/div op per cycle from the reservation-station side and assigns it to a free engine.
- Generates the delayed one-hot start pulse for that engine.
- Round-robin arbitrates finished engines onto the single shared writeback/result port, with a delayed data-select for the result bus.

---
 rtl/fpusqr_pkg.sv | 24 ++
 rtl/fpusqr_rr_arb.sv | 42 ++++
 rtl/fpusqr_sched.sv | 88 ++++++++
 tb/tb_fpusqr_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fpusqr_pkg.sv
// Shared constants and helpers for the FP sqrt/div scheduler.
package fpusqr_pkg;

  localparam int UNITS     = 4;  // rt2_fp engines
  localparam int START_DLY = 3;  // accept -> start_process
  localparam int DATA_DLY  = 5;  // wb grant -> result data select
  localparam int CNT_W     = 3;  // busy counter width, holds UNITS

  typedef logic [UNITS-1:0] uvec_t;

  // Isolate the lowest set bit (two's complement trick).
  function automatic uvec_t onehot_low(uvec_t v);
    return v & (~v + uvec_t'(1));
  endfunction

  // Count set bits of an engine vector.
  function automatic logic [CNT_W-1:0] popcount(uvec_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < UNITS; i++) c = c + {{(CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/fpusqr_rr_arb.sv
// N-way round-robin arbiter: search starts at the pointer, pointer moves
// past the winner. A blocked cycle grants nothing and leaves the pointer.
module fpusqr_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         block,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, ptr_nxt, idx;
  logic          hit;

  // Rotating priority search from ptr; first requester wins.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    idx     = '0;
    if (rst && !block) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(ptr) + k) % N);
        if (!hit && req[idx]) begin
          hit      = 1'b1;
          gnt[idx] = 1'b1;
          ptr_nxt  = PW'((int'(idx) + 1) % N);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/fpusqr_sched.sv
// Issue/retire scheduler for the rt2_fp sqrt/div engines: allocates a free
// engine per accepted op, delays its start pulse, and round-robins finished
// engines onto the shared writeback port.
module fpusqr_sched
  import fpusqr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             in_req,
  output logic             in_pause,
  output logic             in_grant,
  output logic [UNITS-1:0] in_sel,
  input  logic [UNITS-1:0] unit_rdy,
  output logic [UNITS-1:0] unit_start,
  input  logic [UNITS-1:0] unit_done,
  output logic [UNITS-1:0] unit_out_can,
  input  logic             wb_blocked,
  output logic             wb_en,
  output logic [UNITS-1:0] wb_data_sel,
  output logic [CNT_W-1:0] busy_cnt
);

  uvec_t resv, fired, free;
  uvec_t resv_nxt, fired_nxt, fired_now, clr;
  logic [START_DLY-1:0][UNITS-1:0] st_pipe;
  logic [DATA_DLY-1:0][UNITS-1:0]  ds_pipe;

  // An engine is allocatable only if it reports ready and is not already
  // promised to an op that has not yet pulled rdy low.
  assign free       = unit_rdy & ~resv;
  assign in_pause   = ~|free;
  assign in_grant   = rst & in_req & ~in_pause & ~except;
  assign in_sel     = in_grant ? onehot_low(free) : '0;
  assign unit_start = st_pipe[START_DLY-1];
  assign wb_en      = |unit_out_can;
  assign wb_data_sel = ds_pipe[DATA_DLY-1];

  // Reservation bookkeeping: hold until the engine has been started and has
  // dropped rdy; a flush drops only reservations whose start never fired.
  always_comb begin
    fired_now = fired | unit_start;
    clr       = fired & ~unit_rdy;
    resv_nxt  = (resv | in_sel) & ~clr;
    if (except) resv_nxt = resv_nxt & fired_now;
    fired_nxt = fired_now & resv_nxt;
  end

  // Reservation, start pipeline and busy count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resv     <= '0;
      fired    <= '0;
      st_pipe  <= '0;
      busy_cnt <= '0;
    end else begin
      resv     <= resv_nxt;
      fired    <= fired_nxt;
      busy_cnt <= popcount(~unit_rdy | resv);
      if (except) begin
        st_pipe <= '0;
      end else begin
        st_pipe[0] <= in_sel;
        for (int s = 1; s < START_DLY; s++) st_pipe[s] <= st_pipe[s-1];
      end
    end
  end

  // Result-bus select trails the writeback grant; only reset clears it since
  // a started engine's result is still delivered across a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_pipe <= '0;
    end else begin
      ds_pipe[0] <= unit_out_can;
      for (int s = 1; s < DATA_DLY; s++) ds_pipe[s] <= ds_pipe[s-1];
    end
  end

  fpusqr_rr_arb #(.N(UNITS)) u_wb_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (unit_done),
    .block (wb_blocked),
    .gnt   (unit_out_can)
  );

endmodule

// File: tb/tb_fpusqr_sched.sv
// Directed bench for fpusqr_sched with a cycle-level reference model.
module tb_fpusqr_sched;
  import fpusqr_pkg::*;

  logic       clk = 1'b0, rst = 1'b0, except = 1'b0, in_req = 1'b0, wb_blocked = 1'b0;
  logic [3:0] unit_rdy = 4'hF, unit_done = 4'h0;
  logic       in_pause, in_grant, wb_en;
  logic [3:0] in_sel, unit_start, unit_out_can, wb_data_sel;
  logic [2:0] busy_cnt;

  int checks = 0, failures = 0;

  fpusqr_sched dut (
    .clk(clk), .rst(rst), .except(except), .in_req(in_req),
    .in_pause(in_pause), .in_grant(in_grant), .in_sel(in_sel),
    .unit_rdy(unit_rdy), .unit_start(unit_start), .unit_done(unit_done),
    .unit_out_can(unit_out_can), .wb_blocked(wb_blocked), .wb_en(wb_en),
    .wb_data_sel(wb_data_sel), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: per-engine reservation with an absolute due cycle for its
  // start pulse, a writeback pointer, and a history of writeback grants.
  int         cyc = 0;
  bit         m_resv[4], m_fired[4];
  int         m_due[4];
  int         m_p;
  logic [3:0] m_hist[8];
  logic [2:0] m_busy;

  always @(negedge clk) begin
    logic [3:0] e_free, e_sel, e_start, e_can, e_ds;
    logic       e_grant;
    int         widx;
    if (!rst) begin
      chk("rst_in_grant", in_grant, 0);
      chk("rst_in_sel", in_sel, 0);
      chk("rst_unit_start", unit_start, 0);
      chk("rst_out_can", unit_out_can, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_data_sel", wb_data_sel, 0);
      chk("rst_busy", busy_cnt, 0);
      chk("rst_pause", in_pause, (unit_rdy == 4'h0));
      for (int i = 0; i < 4; i++) begin m_resv[i] = 0; m_fired[i] = 0; m_due[i] = -1; end
      for (int i = 0; i < 8; i++) m_hist[i] = 4'h0;
      m_p = 0;
      m_busy = 3'd0;
    end else begin
      e_start = 4'h0; e_free = 4'h0; e_sel = 4'h0; e_can = 4'h0; widx = -1;
      for (int i = 0; i < 4; i++) begin
        e_start[i] = (m_due[i] == cyc);
        e_free[i]  = unit_rdy[i] && !m_resv[i];
      end
      e_grant = in_req && (e_free != 4'h0) && !except;
      for (int i = 3; i >= 0; i--) if (e_free[i]) e_sel = 4'h1 << i;
      if (!e_grant) e_sel = 4'h0;
      if (!wb_blocked)
        for (int k = 0; k < 4; k++)
          if (widx < 0 && unit_done[(m_p + k) % 4]) widx = (m_p + k) % 4;
      if (widx >= 0) e_can = 4'h1 << widx;
      e_ds = m_hist[(cyc + 3) % 8];

      chk("in_pause", in_pause, (e_free == 4'h0));
      chk("in_grant", in_grant, e_grant);
      chk("in_sel", in_sel, e_sel);
      chk("unit_start", unit_start, e_start);
      chk("unit_out_can", unit_out_can, e_can);
      chk("wb_en", wb_en, (e_can != 4'h0));
      chk("wb_data_sel", wb_data_sel, e_ds);
      chk("busy_cnt", busy_cnt, m_busy);

      // advance model to next cycle
      begin
        logic [3:0] rv;
        for (int i = 0; i < 4; i++) rv[i] = m_resv[i];
        m_busy = 3'($countones(~unit_rdy | rv));
      end
      m_hist[cyc % 8] = e_can;
      for (int i = 0; i < 4; i++) begin
        if (m_fired[i] && !unit_rdy[i]) begin m_resv[i] = 0; m_fired[i] = 0; end
        if (m_due[i] == cyc) begin m_fired[i] = 1; m_due[i] = -1; end
        if (except && m_resv[i] && !m_fired[i]) begin m_resv[i] = 0; m_due[i] = -1; end
        if (e_sel[i]) begin m_resv[i] = 1; m_due[i] = cyc + 3; end
      end
      if (widx >= 0) m_p = (widx + 1) % 4;
    end
    cyc++;
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  logic [3:0] wb_seq [4];

  initial begin
    wb_seq[0] = 4'b0001; wb_seq[1] = 4'b0010; wb_seq[2] = 4'b1000; wb_seq[3] = 4'b0001;
    nxt(); nxt();
    rst = 1'b1;

    // single op: grant to unit 0, start 3 cycles later for one cycle
    in_req = 1'b1; neg();
    chk("t1_grant", in_grant, 1); chk("t1_sel", in_sel, 4'b0001);
    nxt(); in_req = 1'b0;
    nxt(); nxt(); neg();
    chk("t1_start", unit_start, 4'b0001); chk("t1_busy", busy_cnt, 1);
    nxt(); unit_rdy = 4'b1110; neg();
    chk("t1_start_off", unit_start, 4'b0000);
    nxt(); unit_rdy = 4'hF;
    nxt();

    // four back-to-back ops fill all engines, fifth is paused
    for (int k = 0; k < 4; k++) begin
      in_req = 1'b1; neg();
      chk("t2_sel", in_sel, 4'h1 << k);
      nxt();
    end
    neg();
    chk("t2_pause", in_pause, 1); chk("t2_nogrant", in_grant, 0);
    nxt(); in_req = 1'b0; neg();
    chk("t2_busy", busy_cnt, 4);
    nxt(); nxt(); unit_rdy = 4'h0;
    nxt(); unit_rdy = 4'hF;
    nxt();

    // grant unit 2 then flush before start
    unit_rdy = 4'b0100; in_req = 1'b1; neg();
    chk("t3_sel", in_sel, 4'b0100);
    nxt(); in_req = 1'b0; except = 1'b1;
    nxt(); except = 1'b0;
    nxt(); neg();
    chk("t3_nostart", unit_start, 4'b0000);
    nxt(); in_req = 1'b1; neg();
    chk("t3_regrant", in_grant, 1); chk("t3_resel", in_sel, 4'b0100);
    nxt(); in_req = 1'b0; except = 1'b1;
    nxt(); except = 1'b0; unit_rdy = 4'hF;
    nxt();

    // round-robin writeback over 1011, then delayed data select
    unit_rdy = 4'b0100; unit_done = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      neg(); chk("t4_can", unit_out_can, wb_seq[k]); chk("t4_wb_en", wb_en, 1);
      nxt();
    end
    unit_done = 4'h0;
    nxt();
    for (int k = 0; k < 4; k++) begin
      neg(); chk("t4_data_sel", wb_data_sel, wb_seq[k]);
      nxt();
    end

    // blocked writeback holds pointer
    unit_done = 4'b0100; wb_blocked = 1'b1; neg();
    chk("t5_blk0", unit_out_can, 0); chk("t5_blk_en", wb_en, 0);
    nxt(); neg();
    chk("t5_blk1", unit_out_can, 0);
    nxt(); wb_blocked = 1'b0; neg();
    chk("t5_can", unit_out_can, 4'b0100);
    nxt(); unit_done = 4'h0; unit_rdy = 4'hF;
    nxt();

    // reset mid-operation
    in_req = 1'b1; neg();
    chk("t6_sel", in_sel, 4'b0001);
    nxt(); in_req = 1'b0; unit_rdy = 4'b1101; unit_done = 4'b0010; neg();
    chk("t6_can", unit_out_can, 4'b0010);
    nxt(); rst = 1'b0; in_req = 1'b1; unit_done = 4'b0001; #1;
    chk("t6_rst_start", unit_start, 0); chk("t6_rst_can", unit_out_can, 0);
    chk("t6_rst_ds", wb_data_sel, 0); chk("t6_rst_grant", in_grant, 0);
    nxt(); nxt(); rst = 1'b1; in_req = 1'b0; unit_done = 4'h0; unit_rdy = 4'hF;
    for (int k = 0; k < 8; k++) begin
      neg(); chk("t6_no_start", unit_start, 0); chk("t6_no_ds", wb_data_sel, 0);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
